// File: rtl/divu_hilo_unit_pkg.sv
// Shared ALU package.
// Holds the ALU funct codes that select the divider and the HI/LO move
// operations, plus the divider's control-state encoding.
package divu_hilo_unit_pkg;

    localparam logic [5:0] FN_SRL  = 6'd2;
    localparam logic [5:0] FN_MFHI = 6'd16;
    localparam logic [5:0] FN_MFLO = 6'd18;
    localparam logic [5:0] FN_DIVU = 6'd27;
    localparam logic [5:0] FN_ADD  = 6'd32;
    localparam logic [5:0] FN_SUB  = 6'd34;
    localparam logic [5:0] FN_AND  = 6'd36;
    localparam logic [5:0] FN_OR   = 6'd37;
    localparam logic [5:0] FN_SLT  = 6'd42;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } div_state_e;

endpackage

// File: rtl/divu_hilo_unit_div_step.sv
// One restoring shift-subtract step of the unsigned divider.
// Ports:
//   rem_in  - partial remainder, top bit dropped (it is always zero before a shift)
//   q_msb   - quotient/dividend register MSB, shifted into the remainder
//   divisor - latched divisor
//   rem_out - next partial remainder
//   q_bit   - quotient bit produced by this step
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-2:0] rem_in,
    input  logic             q_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH-1:0] shifted;
    logic [WIDTH:0]   trial;
    logic             borrow;

    // The extra top bit of the subtraction acts as the borrow flag.
    always_comb begin
        shifted = {rem_in, q_msb};
        trial   = {1'b0, shifted} - {1'b0, divisor};
        borrow  = trial[WIDTH];
        q_bit   = ~borrow;
        rem_out = borrow ? shifted : trial[WIDTH-1:0];
    end

endmodule

// File: rtl/divu_hilo_unit.sv
// Multi-cycle unsigned divider with HI/LO result registers.
// Ports:
//   clk, reset (async, active-high)
//   start          - one-cycle request, accepted only when idle
//   dividend       - unsigned dividend
//   divisor        - unsigned divisor
//   busy           - operation in progress (RUN and FINISH)
//   done           - one-cycle pulse while HI/LO show a fresh result
//   div_by_zero    - sticky, set when the last result used divisor 0
//   hi / lo        - remainder / quotient
module divu_hilo_unit
    import divu_hilo_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    div_state_e       state_q, state_d;
    // A partial remainder is always below 2^(WIDTH-1) before its shift,
    // so only WIDTH-1 bits need storing between steps.
    logic [WIDTH-2:0] rem_q, rem_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] step_rem;
    logic             step_bit;
    logic             last_iter;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_q),
        .q_msb   (q_q[WIDTH-1]),
        .divisor (div_q),
        .rem_out (step_rem),
        .q_bit   (step_bit)
    );

    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rem_q   <= '0;
            q_q     <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            q_q     <= q_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_iter) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The final iteration loads HI/LO directly from the step result, so the
    // new values are already visible during FINISH alongside done.
    always_comb begin
        rem_d = rem_q;
        q_d   = q_q;
        div_d = div_q;
        cnt_d = cnt_q;
        hi_d  = hi_q;
        lo_d  = lo_q;
        dbz_d = dbz_q;
        if (state_q == IDLE && start) begin
            rem_d = '0;
            q_d   = dividend;
            div_d = divisor;
            cnt_d = '0;
            dbz_d = 1'b0;
        end else if (state_q == RUN) begin
            rem_d = step_rem[WIDTH-2:0];
            q_d   = {q_q[WIDTH-2:0], step_bit};
            cnt_d = cnt_q + CNT_W'(1);
            if (last_iter) begin
                hi_d  = step_rem;
                lo_d  = {q_q[WIDTH-2:0], step_bit};
                dbz_d = (div_q == '0);
            end
        end
    end

    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == FINISH);
    end

    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_divu_hilo_unit.sv
// Scoreboard bench for divu_hilo_unit: expected results are queued when an
// operation is issued and a monitor compares them on every done pulse.
module tb_divu_hilo_unit;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } result_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int      checks;
    int      errors;
    result_t exp_q[$];
    logic [31:0] last_hi;
    logic [31:0] last_lo;

    divu_hilo_unit dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer division, divide-by-zero gives all ones / dividend.
    function automatic result_t model(input logic [31:0] a, input logic [31:0] b);
        result_t r;
        if (b == 32'd0) begin
            r.lo  = 32'hFFFF_FFFF;
            r.hi  = a;
            r.dbz = 1'b1;
        end else begin
            r.lo  = a / b;
            r.hi  = a % b;
            r.dbz = 1'b0;
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_done", 32'd1, 32'd0);
            end else begin
                result_t e;
                e = exp_q.pop_front();
                checkOutput("hi", hi, e.hi);
                checkOutput("lo", lo, e.lo);
                checkOutput("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
            end
        end
    end

    // Drives start for one cycle; caller is positioned just after a negedge.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        exp_q.push_back(model(a, b));
        @(negedge clk);
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
    endtask

    // Runs one operation, checking busy, HI/LO hold and latency each cycle.
    // stray_at: cycle to pulse an ignored start (0 = none).
    // reset_at: cycle to assert reset (0 = none).
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input int stray_at, input int reset_at);
        int k;
        result_t e;
        e = model(a, b);
        applyStimulus(a, b);
        for (k = 1; k <= 100; k++) begin
            if (k > 1) @(negedge clk);
            if (k == stray_at) begin
                dividend = 32'd99;
                divisor  = 32'd3;
                start    = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (k == reset_at) begin
                reset = 1'b1;
                #1;
                checkOutput("abort_busy", {31'd0, busy}, 32'd0);
                checkOutput("abort_done", {31'd0, done}, 32'd0);
                checkOutput("abort_hi", hi, 32'd0);
                checkOutput("abort_lo", lo, 32'd0);
                checkOutput("abort_dbz", {31'd0, div_by_zero}, 32'd0);
                exp_q.delete();
                last_hi = 32'd0;
                last_lo = 32'd0;
                @(negedge clk);
                reset = 1'b0;
                return;
            end
            checkOutput("busy", {31'd0, busy}, 32'd1);
            if (k == 1) checkOutput("dbz_cleared", {31'd0, div_by_zero}, 32'd0);
            if (done) break;
            checkOutput("hi_hold", hi, last_hi);
            checkOutput("lo_hold", lo, last_lo);
        end
        checkOutput("latency", k, 33);
        last_hi = e.hi;
        last_lo = e.lo;
        @(negedge clk);
        start = 1'b0;
        checkOutput("done_pulse", {31'd0, done}, 32'd0);
        checkOutput("idle_busy", {31'd0, busy}, 32'd0);
        checkOutput("hi_after", hi, last_hi);
        checkOutput("lo_after", lo, last_lo);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        last_hi  = 32'd0;
        last_lo  = 32'd0;
        reset    = 1'b1;
        start    = 1'b0;
        dividend = 32'd0;
        divisor  = 32'd0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_done", {31'd0, done}, 32'd0);
        checkOutput("reset_dbz", {31'd0, div_by_zero}, 32'd0);
        checkOutput("reset_hi", hi, 32'd0);
        checkOutput("reset_lo", lo, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op(32'd100, 32'd7, 0, 0);
        run_op(32'hFFFF_FFFF, 32'd1, 0, 0);
        run_op(32'd5, 32'd9, 0, 0);
        run_op(32'd1234, 32'd0, 0, 0);
        run_op(32'd1234, 32'd3, 0, 0);
        run_op(32'd42, 32'd5, 10, 0);
        run_op(32'd1000, 32'd10, 0, 15);
        run_op(32'd1000, 32'd10, 0, 0);
        run_op(32'd17, 32'd4, 0, 0);
        run_op(32'd81, 32'd9, 0, 0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        run_op(32'hFFFF_FFFE, 32'h8000_0001, 0, 0);

        for (int i = 0; i < 20; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 15);
            else if ($urandom_range(0, 1) == 0) b = $urandom >> $urandom_range(0, 31);
            else b = $urandom;
            run_op(a, b, 0, 0);
        end

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
